// File: rtl/uart_rx_core_if.sv
// Serial-in / byte-out bundle between the UART receiver and its consumer.
// The receiver takes the slave view; the line driver / byte consumer takes master.
interface uart_rx_core_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_busy;

    modport slave  (input  rx,
                    output rx_data, rx_ready, rx_frame_err, rx_busy);
    modport master (output rx,
                    input  rx_data, rx_ready, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// one-cycle rx_ready / rx_frame_err pulses, break hold-off after a bad stop bit.
module uart_rx_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    // Below 4 clocks per bit the half-bit start check collapses onto the edge.
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    sync_q, sync_d;
    logic          rx_s;

    // Synchroniser shift: bit 0 takes the raw pin, bit 1 is the clean sample.
    always_comb begin
        sync_d = {sync_q[0], bus.rx};
    end

    assign rx_s = sync_q[1];

    // Synchroniser flops reset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end

    // Frame sequencing: START waits half a bit so later samples land mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d  = '0;
                    bidx_d = '0;
                    // Line back high at mid-start: treat as a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    if (bidx_q == 3'd7) state_d = STOP;
                    else                bidx_d  = bidx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = sh_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BRK: begin
                // Held-low line: wait for release rather than decoding 0x00s.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_ready     = ready_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_busy      = (state_q != IDLE);
endmodule
